// File: rtl/ddr4_phy_pkg.sv
// Shared types and constants for the DDR4 read-training controller.
package ddr4_phy_pkg;

  localparam int LANES_DEF        = 16;
  localparam int DELAY_TAPS_DEF   = 64;
  localparam int COARSE_STEPS_DEF = 8;
  localparam int MAX_RETRIES_DEF  = 8;
  localparam int FINE_TIMEOUT_DEF = 256;

  localparam int SETTLE_CYCLES = 2;
  localparam int SAMPLE_CYCLES = 4;
  localparam int MIN_WIDTH     = 4;

  typedef enum logic [3:0] {
    IDLE, C_SET, C_SAMPLE, C_EVAL, F_START, F_WAIT, MERGE, LOCKED, FAILED
  } state_t;

endpackage

// File: rtl/ddr4_fsm_if.sv
// Handshake and per-lane result bus between the training FSM and the fine-search engine.
interface ddr4_fsm_if #(
  parameter int LANES      = 16,
  parameter int DELAY_TAPS = 64
);
  localparam int TW = $clog2(DELAY_TAPS);
  localparam int WW = $clog2(DELAY_TAPS + 1);

  logic                       fine_start;
  logic                       fine_done;
  logic                       fine_failed;
  logic [LANES-1:0]           lane_valid;
  logic [LANES-1:0][TW-1:0]   best_start;
  logic [LANES-1:0][TW-1:0]   best_end;
  logic [LANES-1:0][WW-1:0]   best_width;

  modport master (output fine_start,
                  input  fine_done, fine_failed, lane_valid, best_start, best_end, best_width);
  modport slave  (input  fine_start,
                  output fine_done, fine_failed, lane_valid, best_start, best_end, best_width);
endinterface

// File: rtl/ddr4_window_merge.sv
// Running intersection of per-lane eye windows, one lane presented per scan cycle.
module ddr4_window_merge
  import ddr4_phy_pkg::*;
#(
  parameter int TW = 6,
  parameter int WW = 7
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          scan,
  input  logic          valid,
  input  logic [TW-1:0] win_start,
  input  logic [TW-1:0] win_end,
  input  logic [WW-1:0] width,
  output logic          any_nx,
  output logic [TW-1:0] lo_nx,
  output logic [TW-1:0] hi_nx
);

  logic          any_q;
  logic [TW-1:0] lo_q;
  logic [TW-1:0] hi_q;
  logic          usable;

  // Outputs already include the lane on the bus so the caller can decide on the last scan cycle.
  always_comb begin
    usable = valid && (width >= WW'(MIN_WIDTH)) && (win_start <= win_end);
    any_nx = any_q;
    lo_nx  = lo_q;
    hi_nx  = hi_q;
    if (usable) begin
      any_nx = 1'b1;
      lo_nx  = (!any_q || win_start > lo_q) ? win_start : lo_q;
      hi_nx  = (!any_q || win_end   < hi_q) ? win_end   : hi_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      any_q <= 1'b0;
    end else if (scan) begin
      any_q <= any_nx;
      lo_q  <= lo_nx;
      hi_q  <= hi_nx;
    end
  end

endmodule

// File: rtl/ddr4_fsm.sv
// DDR4 read-training FSM: coarse sweep, fine-search handoff, lane window merge, retry.
// Define DDR4_FSM_DRIFT_RETRAIN_EN to re-run the fine search from LOCKED on drift_detected.
module ddr4_fsm
  import ddr4_phy_pkg::*;
#(
  parameter int LANES        = LANES_DEF,
  parameter int DELAY_TAPS   = DELAY_TAPS_DEF,
  parameter int COARSE_STEPS = COARSE_STEPS_DEF,
  parameter int MAX_RETRIES  = MAX_RETRIES_DEF,
  parameter int FINE_TIMEOUT = FINE_TIMEOUT_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_training,
  input  logic [LANES-1:0]                read_ok,
  input  logic                            drift_detected,
  ddr4_fsm_if.master                      fine,
  output logic [$clog2(DELAY_TAPS)-1:0]   delay_tap,
  output logic                            locked,
  output logic                            training_done,
  output logic                            training_failed,
  output logic [$clog2(MAX_RETRIES)-1:0]  retry_count,
  output logic [$clog2(COARSE_STEPS)-1:0] coarse_sel,
  output logic [$clog2(DELAY_TAPS)-1:0]   final_delay_tap
);

  localparam int TW      = $clog2(DELAY_TAPS);
  localparam int WW      = $clog2(DELAY_TAPS + 1);
  localparam int CW      = $clog2(COARSE_STEPS);
  localparam int RW      = $clog2(MAX_RETRIES);
  localparam int LW      = $clog2(LANES);
  localparam int NW      = $clog2(LANES + 1);
  localparam int SW      = $clog2(SAMPLE_CYCLES * LANES + 1);
  localparam int KW      = $clog2((FINE_TIMEOUT > LANES ? FINE_TIMEOUT : LANES) + 1);
  localparam int SPACING = DELAY_TAPS / COARSE_STEPS;

`ifdef DDR4_FSM_DRIFT_RETRAIN_EN
  localparam bit DRIFT_EN = 1'b1;
`else
  localparam bit DRIFT_EN = 1'b0;
`endif

  function automatic logic [TW-1:0] coarse_tap(input logic [CW-1:0] s);
    coarse_tap = TW'(int'(s) * SPACING + SPACING / 2);
  endfunction

  function automatic logic [NW-1:0] popcount(input logic [LANES-1:0] v);
    popcount = '0;
    for (int i = 0; i < LANES; i++) popcount = popcount + NW'(v[i]);
  endfunction

  state_t          state, state_nx;
  logic [KW-1:0]   cnt;
  logic [CW-1:0]   step, set_step, best_step, best_step_nx;
  logic [SW-1:0]   score, best_score, best_score_nx;
  logic            restart, attempt_fail, enter_set, last_step, last_retry;
  logic [LW-1:0]   lane;
  logic            merge_any;
  logic [TW-1:0]   merge_lo, merge_hi, merge_mid;

  assign lane          = cnt[LW-1:0];
  assign last_step     = (step == CW'(COARSE_STEPS - 1));
  assign last_retry    = (retry_count == RW'(MAX_RETRIES - 1));
  // Strictly-greater update keeps the lowest step on ties.
  assign best_score_nx = (score > best_score) ? score : best_score;
  assign best_step_nx  = (score > best_score) ? step  : best_step;
  assign merge_mid     = TW'(({1'b0, merge_lo} + {1'b0, merge_hi}) >> 1);

  ddr4_window_merge #(.TW(TW), .WW(WW)) u_merge (
    .clk       (clk),
    .clear     (state != MERGE),
    .scan      (state == MERGE),
    .valid     (fine.lane_valid[lane]),
    .win_start (fine.best_start[lane]),
    .win_end   (fine.best_end[lane]),
    .width     (fine.best_width[lane]),
    .any_nx    (merge_any),
    .lo_nx     (merge_lo),
    .hi_nx     (merge_hi)
  );

  always_comb begin
    state_nx     = state;
    restart      = 1'b0;
    attempt_fail = 1'b0;
    unique case (state)
      IDLE:     if (start_training) restart = 1'b1;
      C_SET:    if (cnt == KW'(SETTLE_CYCLES - 1)) state_nx = C_SAMPLE;
      C_SAMPLE: if (cnt == KW'(SAMPLE_CYCLES - 1)) state_nx = C_EVAL;
      C_EVAL: begin
        if (!last_step)               state_nx = C_SET;
        else if (best_score_nx == '0) attempt_fail = 1'b1;
        else                          state_nx = F_START;
      end
      F_START:  state_nx = F_WAIT;
      F_WAIT: begin
        if (fine.fine_failed)                      attempt_fail = 1'b1;
        else if (fine.fine_done)                   state_nx = MERGE;
        else if (cnt == KW'(FINE_TIMEOUT - 1))     attempt_fail = 1'b1;
      end
      MERGE: begin
        if (cnt == KW'(LANES - 1)) begin
          if (merge_any && (merge_lo <= merge_hi)) state_nx = LOCKED;
          else                                     attempt_fail = 1'b1;
        end
      end
      LOCKED: begin
        if (start_training)                  restart = 1'b1;
        else if (DRIFT_EN && drift_detected) state_nx = F_START;
      end
      FAILED:   if (start_training) restart = 1'b1;
      default:  state_nx = IDLE;
    endcase
    if (restart)      state_nx = C_SET;
    if (attempt_fail) state_nx = last_retry ? FAILED : C_SET;
  end

  assign enter_set = (state_nx == C_SET) && (state != C_SET);
  assign set_step  = (restart || attempt_fail) ? '0 : step + CW'(1);

  assign fine.fine_start  = (state == F_START);
  assign locked           = (state == LOCKED);
  assign training_done    = (state == LOCKED);
  assign training_failed  = (state == FAILED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      step            <= '0;
      retry_count     <= '0;
      coarse_sel      <= '0;
      delay_tap       <= '0;
      final_delay_tap <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + KW'(1);
      if (restart)                           retry_count <= '0;
      else if (attempt_fail && !last_retry)  retry_count <= retry_count + RW'(1);
      if (enter_set) begin
        step      <= set_step;
        delay_tap <= coarse_tap(set_step);
      end
      if (state == C_EVAL && state_nx == F_START) coarse_sel <= best_step_nx;
      if (state == MERGE && state_nx == LOCKED) begin
        final_delay_tap <= merge_mid;
        delay_tap       <= merge_mid;
      end
    end
  end

  // Sweep scoring datapath; cleared whenever a sweep (re)starts.
  always_ff @(posedge clk) begin
    if (enter_set)               score <= '0;
    else if (state == C_SAMPLE)  score <= score + SW'(popcount(read_ok));
    if (state == C_EVAL) begin
      best_score <= best_score_nx;
      best_step  <= best_step_nx;
    end
    if (restart || attempt_fail) begin
      best_score <= '0;
      best_step  <= '0;
    end
  end

endmodule

// File: tb/tb_ddr4_fsm.sv
// Bench for ddr4_fsm: table vectors, randomized windows against a reference model, corner sequences.
`timescale 1ns/1ps
module tb_ddr4_fsm;
  import ddr4_phy_pkg::*;

  localparam int LANES        = 16;
  localparam int DELAY_TAPS   = 64;
  localparam int COARSE_STEPS = 8;
  localparam int MAX_RETRIES  = 8;
  localparam int FINE_TIMEOUT = 256;
  localparam int SPACING      = DELAY_TAPS / COARSE_STEPS;

  logic             clk = 1'b0;
  logic             rst, start_training, drift_detected;
  logic [LANES-1:0] read_ok;
  logic [5:0]       delay_tap, final_delay_tap;
  logic             locked, training_done, training_failed;
  logic [2:0]       retry_count, coarse_sel;

  ddr4_fsm_if #(.LANES(LANES), .DELAY_TAPS(DELAY_TAPS)) fif ();

  ddr4_fsm #(.LANES(LANES), .DELAY_TAPS(DELAY_TAPS), .COARSE_STEPS(COARSE_STEPS),
             .MAX_RETRIES(MAX_RETRIES), .FINE_TIMEOUT(FINE_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start_training(start_training), .read_ok(read_ok),
    .drift_detected(drift_detected), .fine(fif), .delay_tap(delay_tap), .locked(locked),
    .training_done(training_done), .training_failed(training_failed), .retry_count(retry_count),
    .coarse_sel(coarse_sel), .final_delay_tap(final_delay_tap)
  );

  always #5 clk = ~clk;

  int rd_lo[LANES], rd_hi[LANES];
  int w_lo[LANES], w_hi[LANES], w_width[LANES];
  bit w_vld[LANES];
  int fine_mode, fine_lat, fs_count, pend;
  int n_checks = 0, n_fail = 0;

  // Memory model: a lane reads correctly when the applied tap is inside its data eye.
  always_comb begin
    read_ok = '0;
    for (int l = 0; l < LANES; l++)
      read_ok[l] = (int'(delay_tap) >= rd_lo[l]) && (int'(delay_tap) <= rd_hi[l]);
  end

  always_comb begin
    fif.lane_valid = '0;
    fif.best_start = '0;
    fif.best_end   = '0;
    fif.best_width = '0;
    for (int l = 0; l < LANES; l++) begin
      fif.lane_valid[l] = w_vld[l];
      fif.best_start[l] = 6'(w_lo[l]);
      fif.best_end[l]   = 6'(w_hi[l]);
      fif.best_width[l] = 7'(w_width[l]);
    end
  end

  // Fine engine: 0 = done, 1 = silent, 3 = done and failed together; answers fine_lat cycles after fine_start.
  initial begin
    fif.fine_done = 1'b0; fif.fine_failed = 1'b0; fs_count = 0; pend = 0;
    forever begin
      @(negedge clk);
      fif.fine_done = 1'b0; fif.fine_failed = 1'b0;
      if (fif.fine_start) begin
        fs_count++;
        pend = (fine_mode == 1) ? 0 : fine_lat;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fif.fine_done   = 1'b1;
          fif.fine_failed = (fine_mode == 3);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_read(input int lo, input int hi);
    for (int l = 0; l < LANES; l++) begin rd_lo[l] = lo; rd_hi[l] = hi; end
  endtask

  task automatic set_win(input int l, input bit v, input int lo, input int hi);
    w_vld[l] = v; w_lo[l] = lo; w_hi[l] = hi;
    w_width[l] = (hi >= lo) ? hi - lo + 1 : 0;
  endtask

  task automatic set_groups(input int alo, input int ahi, input int blo, input int bhi);
    for (int l = 0; l < LANES; l++)
      if (l < LANES / 2) set_win(l, 1'b1, alo, ahi);
      else               set_win(l, 1'b1, blo, bhi);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_training = 1'b0; drift_detected = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_training = 1'b1;
    @(negedge clk); start_training = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (locked || training_failed) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fine_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fif.fine_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic cycles_to_retry1(input int budget, output int t);
    t = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (retry_count == 3'd1) begin t = i; break; end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_delay_tap"}, delay_tap, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_done"}, training_done, 0);
    check({tag, "_failed"}, training_failed, 0);
    check({tag, "_retry"}, retry_count, 0);
    check({tag, "_coarse"}, coarse_sel, 0);
    check({tag, "_final"}, final_delay_tap, 0);
    check({tag, "_fine_start"}, fif.fine_start, 0);
  endtask

  // Reference: score each coarse point by passing lanes, pick first maximum, intersect usable windows.
  function automatic void model(output bit exp_lock, output int exp_coarse, output int exp_final);
    int best_sc, tap, sc, lo, hi;
    bit any;
    best_sc = 0; exp_coarse = 0; lo = 0; hi = DELAY_TAPS - 1; any = 1'b0;
    for (int c = 0; c < COARSE_STEPS; c++) begin
      tap = c * SPACING + SPACING / 2;
      sc = 0;
      for (int l = 0; l < LANES; l++) if (tap >= rd_lo[l] && tap <= rd_hi[l]) sc += 4;
      if (sc > best_sc) begin best_sc = sc; exp_coarse = c; end
    end
    for (int l = 0; l < LANES; l++)
      if (w_vld[l] && w_width[l] >= 4 && w_lo[l] <= w_hi[l]) begin
        lo = (!any || w_lo[l] > lo) ? w_lo[l] : lo;
        hi = (!any || w_hi[l] < hi) ? w_hi[l] : hi;
        any = 1'b1;
      end
    exp_lock  = (best_sc > 0) && any && (lo <= hi);
    exp_final = (lo + hi) / 2;
  endfunction

  typedef struct {
    int rlo, rhi, alo, ahi, blo, bhi;
    bit lock;
    int coarse, fin;
  } vec_t;

  vec_t tbl[9];

  task automatic check_outcome(input string tag, input bit ok, input bit lk,
                               input int coarse, input int fin, input int fs_delta);
    check({tag, "_finished"}, ok, 1);
    check({tag, "_locked"}, locked, lk);
    check({tag, "_done"}, training_done, lk);
    check({tag, "_failed"}, training_failed, !lk);
    if (lk) begin
      check({tag, "_coarse"}, coarse_sel, coarse);
      check({tag, "_final"}, final_delay_tap, fin);
      check({tag, "_tap"}, delay_tap, fin);
      check({tag, "_retry"}, retry_count, 0);
      check({tag, "_fine_starts"}, fs_delta, 1);
    end else begin
      check({tag, "_retry"}, retry_count, MAX_RETRIES - 1);
    end
  endtask

  initial begin
    bit ok, elock;
    int ecoarse, efinal, fs0, t;

    rst = 1'b1; start_training = 1'b0; drift_detected = 1'b0;
    fine_mode = 0; fine_lat = 3;
    set_read(1, 0); set_groups(4, 18, 4, 18);

    tbl[0] = '{2, 20, 4, 18, 4, 18, 1'b1, 0, 11};
    tbl[1] = '{2, 20, 3, 15, 6, 20, 1'b1, 0, 10};
    tbl[2] = '{1, 0, 4, 18, 4, 18, 1'b0, 0, 0};
    tbl[3] = '{30, 50, 10, 30, 20, 40, 1'b1, 4, 25};
    tbl[4] = '{2, 20, 3, 8, 10, 20, 1'b0, 0, 0};
    tbl[5] = '{60, 63, 0, 63, 0, 63, 1'b1, 7, 31};
    tbl[6] = '{2, 20, 5, 9, 0, 2, 1'b1, 0, 7};
    tbl[7] = '{2, 20, 8, 11, 9, 30, 1'b1, 0, 10};
    tbl[8] = '{10, 30, 4, 18, 4, 18, 1'b1, 1, 11};

    do_reset();
    check_zero("reset");

    for (int i = 0; i < 9; i++) begin
      do_reset();
      set_read(tbl[i].rlo, tbl[i].rhi);
      set_groups(tbl[i].alo, tbl[i].ahi, tbl[i].blo, tbl[i].bhi);
      fs0 = fs_count;
      pulse_start();
      wait_done(3000, ok);
      check_outcome($sformatf("vec%0d", i), ok, tbl[i].lock, tbl[i].coarse, tbl[i].fin, fs_count - fs0);
    end

    for (int r = 0; r < 12; r++) begin
      do_reset();
      fine_lat = $urandom_range(1, 5);
      for (int l = 0; l < LANES; l++) begin
        rd_lo[l] = $urandom_range(0, 40);
        rd_hi[l] = rd_lo[l] + $urandom_range(0, 20);
        set_win(l, $urandom_range(0, 9) != 0, $urandom_range(0, 14), $urandom_range(12, 50));
        if ($urandom_range(0, 7) == 0 && w_width[l] > 0) w_width[l] = 3;
      end
      model(elock, ecoarse, efinal);
      fs0 = fs_count;
      pulse_start();
      wait_done(3000, ok);
      check_outcome($sformatf("rand%0d", r), ok, elock, ecoarse, efinal, fs_count - fs0);
    end
    fine_lat = 3;

    // Fine engine silent: timeout after FINE_TIMEOUT cycles in F_WAIT, then the sweep restarts at step 0.
    do_reset();
    set_read(2, 20); set_groups(4, 18, 4, 18);
    fine_mode = 1;
    pulse_start();
    wait_fine_start(200, ok);
    check("timeout_fine_start", ok, 1);
    cycles_to_retry1(400, t);
    check("timeout_cycles", t, FINE_TIMEOUT + 1);
    check("timeout_restart_tap", delay_tap, SPACING / 2);
    check("timeout_locked", locked, 0);
    wait_fine_start(200, ok);
    check("timeout_second_attempt", ok, 1);
    fine_mode = 0;

    // fine_done and fine_failed together count as a failed attempt.
    do_reset();
    fine_mode = 3; fine_lat = 2;
    pulse_start();
    wait_fine_start(200, ok);
    check("both_fine_start", ok, 1);
    cycles_to_retry1(50, t);
    check("both_failed_wins", t, 3);
    check("both_locked", locked, 0);
    fine_mode = 0; fine_lat = 3;

    // Exhaust retries, then restart from FAILED.
    do_reset();
    set_read(1, 0);
    pulse_start();
    wait_done(3000, ok);
    check("failed_reached", training_failed, 1);
    check("failed_retry", retry_count, MAX_RETRIES - 1);
    set_read(2, 20);
    pulse_start();
    check("failed_restart_flag", training_failed, 0);
    check("failed_restart_retry", retry_count, 0);
    wait_done(3000, ok);
    check("failed_relock", locked, 1);
    check("failed_relock_final", final_delay_tap, 11);

    // Restart from LOCKED, then drift handling.
    pulse_start();
    check("relock_drop", locked, 0);
    wait_done(3000, ok);
    check("relock_locked", locked, 1);
    set_groups(8, 20, 8, 20);
    fs0 = fs_count;
    @(negedge clk); drift_detected = 1'b1;
    @(negedge clk); drift_detected = 1'b0;
`ifdef DDR4_FSM_DRIFT_RETRAIN_EN
    check("drift_locked_drop", locked, 0);
    check("drift_done_drop", training_done, 0);
    wait_done(1000, ok);
    check("drift_relock", locked, 1);
    check("drift_final", final_delay_tap, 14);
    check("drift_tap", delay_tap, 14);
    check("drift_coarse", coarse_sel, 0);
    check("drift_retry", retry_count, 0);
    check("drift_fine_starts", fs_count - fs0, 1);
`else
    repeat (40) @(negedge clk);
    check("drift_ignored_locked", locked, 1);
    check("drift_ignored_final", final_delay_tap, 11);
    check("drift_ignored_fine_starts", fs_count - fs0, 0);
`endif

    // One-cycle reset while sampling the first coarse point.
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check("presample_tap", delay_tap, SPACING / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("rst_mid");
    repeat (20) @(negedge clk);
    check("idle_hold_tap", delay_tap, 0);
    check("idle_hold_locked", locked, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr4_fsm.md
DDR4_FSM -- requirements
Module: ddr4_fsm

Interface
REQ-001 SHALL have parameter LANES, default 16, number of byte lanes.
REQ-002 SHALL have parameter DELAY_TAPS, default 64, delay-line taps.
REQ-003 SHALL have parameter COARSE_STEPS, default 8, coarse sweep points.
REQ-004 SHALL have parameter MAX_RETRIES, default 8, training attempts before failure.
REQ-005 SHALL have parameter FINE_TIMEOUT, default 256, cycles to wait for fine result.
REQ-006 SHALL use one clock and a synchronous active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports start_training in 1 (start pulse); read_ok in LANES (per-lane read pass); drift_detected in 1 (drift flag).
REQ-008 SHALL have ports fine_done in 1 and fine_failed in 1 (fine-engine result pulses); lane_valid in LANES (per-lane window found).
REQ-009 SHALL have ports best_start in LANES x clog2(DELAY_TAPS) (window start per lane); best_end in LANES x clog2(DELAY_TAPS) (window end per lane); best_width in LANES x clog2(DELAY_TAPS+1) (window width per lane).
REQ-010 SHALL have outputs delay_tap clog2(DELAY_TAPS) (applied tap); locked 1; training_done 1; training_failed 1.
REQ-011 SHALL have outputs retry_count clog2(MAX_RETRIES); coarse_sel clog2(COARSE_STEPS); fine_start 1 (one-cycle pulse); final_delay_tap clog2(DELAY_TAPS).

Function
REQ-012 SHALL implement states IDLE, C_SET, C_SAMPLE, C_EVAL, F_START, F_WAIT, MERGE, LOCKED, FAILED.
REQ-013 SHALL stay in IDLE until start_training=1, then clear retry_count and go to C_SET.
REQ-014 SHALL, in C_SET for step c, drive delay_tap = c*(DELAY_TAPS/COARSE_STEPS) + (DELAY_TAPS/COARSE_STEPS)/2 and wait 2 settle cycles.
REQ-015 SHALL, in C_SAMPLE, add popcount(read_ok) to the score for step c on each of 4 consecutive cycles, with the score width sized for no overflow.
REQ-016 SHALL update the best step only when a step's score is strictly greater than the best so far, so ties keep the lower index; the sweep SHALL cover steps 0..COARSE_STEPS-1.
REQ-017 SHALL treat a best score of 0 as an attempt failure; otherwise it SHALL set coarse_sel to the best step and enter F_START.
REQ-018 SHALL assert fine_start for exactly one cycle in F_START, then enter F_WAIT.
REQ-019 In F_WAIT, fine_failed or a timeout at FINE_TIMEOUT cycles SHALL cause attempt failure; fine_done SHALL lead to MERGE. If fine_done and fine_failed are both set in one cycle, fine_failed SHALL win.
REQ-020 MERGE SHALL scan one lane per cycle (LANES cycles).
REQ-021 A lane SHALL be usable only if lane_valid=1, best_width>=4 and best_start<=best_end; MERGE SHALL take lo = max of usable best_start and hi = min of usable best_end.
REQ-022 If there is no usable lane or lo>hi, MERGE SHALL cause attempt failure; otherwise it SHALL set final_delay_tap=(lo+hi)>>1 and delay_tap=final_delay_tap, and enter LOCKED.
REQ-023 In LOCKED, locked and training_done SHALL both be high as levels.
REQ-024 On attempt failure, retry_count SHALL increment and the FSM SHALL restart at C_SET; if retry_count==MAX_RETRIES-1 at the failure, it SHALL go to FAILED instead.
REQ-025 FAILED SHALL hold training_failed=1 until start_training, which SHALL restart training from C_SET with retry_count=0.
REQ-026 start_training SHALL be ignored in every state except IDLE, LOCKED and FAILED; in LOCKED it SHALL drop locked and training_done and restart training.

Reset
REQ-027 While rst=1, the FSM SHALL go to IDLE and every output SHALL be 0, including fine_start.
REQ-028 Reset SHALL abort any operation in progress in the same cycle.

Configuration
REQ-029 With macro DDR4_FSM_DRIFT_RETRAIN_EN defined, drift_detected=1 in LOCKED SHALL drop locked and training_done and enter F_START, keeping coarse_sel and leaving retry_count unchanged.
REQ-030 Without DDR4_FSM_DRIFT_RETRAIN_EN, drift_detected SHALL be ignored.

Structure
REQ-031 Package ddr4_phy_pkg SHALL hold the state enum, the default parameter constants, and the settle count 2, sample count 4 and minimum width 4.
REQ-032 The lane intersection logic SHALL be a sub-module named ddr4_window_merge.

Verification
REQ-033 Bench: all lanes read_ok=1 only when delay_tap is in [2,20]; fine result gives windows [4,18] on all lanes -> coarse_sel=0, final_delay_tap=11, locked=1, training_done=1.
REQ-034 Bench: read_ok always 0 -> 8 attempts, then training_failed=1 with retry_count=7.
REQ-035 Bench: lane windows [3,15] and [6,20] on the other lanes -> final_delay_tap=10.
REQ-036 Bench: fine engine never answers -> timeout after 256 cycles, retry_count increments, sweep restarts.
REQ-037 Bench: from LOCKED, with DDR4_FSM_DRIFT_RETRAIN_EN defined, pulse drift_detected -> locked falls, one fine_start pulse, re-lock with the new window centre; without the macro -> no change.
REQ-038 Bench: assert rst for one cycle during C_SAMPLE -> all outputs 0 and state IDLE on the next cycle.
